rca_4bit: RTL and testbench

- 4-bit ripple-carry adder with a registered output stage: Sum/Cout = A + B + Cin.
- Carry chain is built from four explicit 1-bit full-adder cells chained LSB to MSB. No lookahead logic.
- Used as the basic small-width adder primitive in datapaths that need a registered result with valid qualification.

---
 rtl/rca_4bit.sv | 86 ++++++++
 tb/tb_rca_4bit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rca_4bit.sv
// Ripple-carry adder with a one-cycle registered result stage.
// The carry chain is a string of explicit full-adder cells, with no lookahead.

module rca_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

module rca_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;
  logic             ovf_next;

  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             valid_reg;

  assign carry[0] = Cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      rca_fa u_fa (
        .a  (A[gi]),
        .b  (B[gi]),
        .ci (carry[gi]),
        .s  (sum_next[gi]),
        .co (carry[gi+1])
      );
    end
  endgenerate

  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign cout_next = carry[WIDTH];
  assign ovf_next  = carry[WIDTH-1] ^ carry[WIDTH];

  // Result registers hold their value when in_valid is low; only the
  // valid flag drops, so downstream logic can still peek at the last sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        sum_reg  <= sum_next;
        cout_reg <= cout_next;
        ovf_reg  <= ovf_next;
      end
    end
  end

  assign Sum       = sum_reg;
  assign Cout      = cout_reg;
  assign Ovf       = ovf_reg;
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_rca_4bit.sv
// Self-checking bench for rca_4bit: directed cases, reset/hold behaviour,
// exhaustive operand sweep and random traffic against an arithmetic model.

module tb_rca_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] Sum;
  logic       Cout;
  logic       Ovf;
  logic       out_valid;

  int pass_count = 0;
  int total      = 0;

  rca_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Reference model: unsigned total and signed-range overflow from plain integers.
  function automatic logic [4:0] ref_total(input int a, input int b, input int c);
    return 5'(a + b + c);
  endfunction

  function automatic logic ref_ovf(input int a, input int b, input int c);
    int sa, sb, s;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    s  = sa + sb + c;
    return (s < -8) || (s > 7);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) pass_count++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present one sample at the falling edge, then check one cycle later.
  task automatic apply(input int a, input int b, input int c);
    logic [4:0] et;
    logic       eo;
    @(negedge clk);
    in_valid = 1'b1;
    A   = 4'(a);
    B   = 4'(b);
    Cin = 1'(c);
    et  = ref_total(a, b, c);
    eo  = ref_ovf(a, b, c);
    @(posedge clk);
    #1;
    $display("txn A=%b B=%b Cin=%0d -> Sum=%b Cout=%0d Ovf=%0d out_valid=%0d",
             4'(a), 4'(b), c, Sum, Cout, Ovf, out_valid);
    check("total", {3'b0, Cout, Sum}, {3'b0, et});
    check("ovf", {7'b0, Ovf}, {7'b0, eo});
    check("out_valid", {7'b0, out_valid}, 8'd1);
  endtask

  task automatic idle_cycle(input logic [3:0] es, input logic ec, input logic eo);
    @(negedge clk);
    in_valid = 1'b0;
    A = 4'($urandom_range(0, 15));
    B = 4'($urandom_range(0, 15));
    Cin = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    $display("txn idle -> Sum=%b Cout=%0d Ovf=%0d out_valid=%0d", Sum, Cout, Ovf, out_valid);
    check("hold_valid", {7'b0, out_valid}, 8'd0);
    check("hold_sum", {4'b0, Sum}, {4'b0, es});
    check("hold_cout", {7'b0, Cout}, {7'b0, ec});
    check("hold_ovf", {7'b0, Ovf}, {7'b0, eo});
  endtask

  task automatic check_zero(input string tag);
    check(tag, {3'b0, out_valid, Ovf, Cout, Sum == 4'd0}, 8'h01);
  endtask

  initial begin
    // Reset with aggressive inputs present; they must be discarded.
    rst = 1'b1; in_valid = 1'b1; A = 4'hF; B = 4'hF; Cin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      $display("txn reset -> Sum=%b Cout=%0d Ovf=%0d out_valid=%0d", Sum, Cout, Ovf, out_valid);
      check_zero("reset");
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_zero("post_reset_idle");

    // Basic, carry-in/overflow, full-ripple cases, back to back.
    apply(0, 0, 0);
    apply(1, 1, 0);
    apply(2, 3, 0);
    apply(5, 3, 1);
    apply(7, 1, 0);
    apply(15, 1, 1);
    apply(15, 15, 1);
    apply(8, 8, 0);

    // Hold: outputs keep 0101 while in_valid is low.
    apply(2, 3, 0);
    for (int i = 0; i < 3; i++) idle_cycle(4'b0101, 1'b0, 1'b0);

    // Mid-stream reset discards the concurrent valid sample.
    apply(9, 9, 1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; A = 4'hF; B = 4'hF; Cin = 1'b1;
    @(posedge clk);
    #1;
    $display("txn midreset -> Sum=%b Cout=%0d Ovf=%0d out_valid=%0d", Sum, Cout, Ovf, out_valid);
    check_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive sweep of all operand and carry-in combinations.
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          apply(a, b, c);

    // Random traffic with occasional idle gaps.
    for (int i = 0; i < 200; i++) begin
      int ra, rb, rc;
      ra = int'($urandom_range(0, 15));
      rb = int'($urandom_range(0, 15));
      rc = int'($urandom_range(0, 1));
      apply(ra, rb, rc);
      if ($urandom_range(0, 7) == 0)
        idle_cycle(Sum, Cout, Ovf);
    end

    @(negedge clk);
    in_valid = 1'b0;
    $display("%0d/%0d checks passed", pass_count, total);
    $finish;
  end

endmodule
